tl_monitor: RTL and testbench
=============================

# tl_monitor

Passive checker for the 6-bit traffic-light bus `TL` driven by the intersection controller. It samples `TL` every clock and decodes it into one of the four legal phases. It measures how long each phase lasts and checks pattern legality, phase order and phase duration, and flags stuck lights. It sits beside the controller in the top level and drives only status and error outputs, never `TL`.

## Interface
- `G_MAIN`, default 4: required cycles of main-green phase P0.
- `Y_MAIN`, default 1: required cycles of main-yellow phase P1.
- `G_SIDE`, default 2: required cycles of side-green phase P2.
- `Y_SIDE`, default 1: required cycles of side-yellow phase P3.
- `MAX_RUN`, default 12: stuck threshold in cycles. Legal range is greater than every phase parameter and at most 15.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `TL` in 6: light bus. [5:3] is main street, [2:0] is side street; per street 100=green, 010=yellow, 001=red.
- `phase` out 2: decoded phase of the registered pattern (0..3 = P0..P3).
- `phase_valid` out 1: registered pattern is P0..P3.
- `last_len` out 4: length of the most recently completed phase.
- `cycle_done` out 1: one-cycle pulse when a full error-free P0..P3 round completes.
- `err` out 1: sticky error flag.
- `err_code` out 3: code of the first error since reset (1 illegal, 2 sequence, 3 duration, 4 stuck).
- `err_cnt` out 8: count of all errors, saturating at 255.

## Operation
- Legal patterns: P0=100001, P1=010001, P2=001100, P3=001010, DARK=000000. Every other value is illegal.
- Registers:
  - `tl_q` holds the last sampled `TL`; reset value 111111 (unknown, never flagged).
  - `run_len` (4 bit, saturates at 15) holds cycles the `tl_q` pattern has been held.
  - `round_ok` flag.
- Every edge:
  - If `TL` == `tl_q`, `run_len` increments.
  - Otherwise a transition occurs: `run_len`<=1 and the ending phase (pattern `tl_q`, length `run_len`) is evaluated.
  - Then `tl_q`<=`TL`.
- FSM, two states:
  - SYNC (reset state): no sequence, duration or stuck checks. Go to TRACK at an edge where `TL`=P0 and `tl_q` is DARK or P3. `round_ok`<=1 on that edge.
  - TRACK: on each transition, check in priority order:
    - Illegal `TL`: error 1, go to SYNC.
    - `TL`=DARK: go to SYNC, no error (controller reset).
    - `TL` not the successor of `tl_q` (P0→P1→P2→P3→P0): error 2, go to SYNC.
    - Ending `run_len` not equal to that phase's parameter: error 3, `round_ok`<=0, stay in TRACK.
  - TRACK stuck check: if `run_len` reaches `MAX_RUN` with no transition, error 4 on that edge, go to SYNC. The stuck error fires once.
  - Illegal `TL` in SYNC also raises error 1.
- `last_len`<=`run_len` on every transition whose ending pattern is P0..P3, in either state.
- `cycle_done`=1 for one cycle on a TRACK transition P3→P0 with `round_ok`=1 and no error on that edge. `round_ok`<=1 again at every P0 entry.
- Error recording:
  - Any error sets `err`<=1 and increments `err_cnt`.
  - `err_code` is written only while `err`=0; later errors never overwrite it.
  - At most one error per edge; the highest-priority error is recorded.
- Only `reset` clears `err`, `err_code` and `err_cnt`.

## Timing
- Reset values:
  - `phase`=0, `phase_valid`=0, `last_len`=0, `cycle_done`=0, `err`=0, `err_code`=0, `err_cnt`=0.
  - `tl_q`=111111, `run_len`=0, FSM in SYNC.
- `reset` low overrides every other event on the same edge.
- Latency: every output reflects `TL` as it was one cycle earlier (registered on the edge that samples the new pattern).
- `phase` and `phase_valid` are registered decodes of `TL`, valid in the same cycle `tl_q` updates.
- `run_len` saturates at 15. For `MAX_RUN`=15, the stuck check fires at the saturating edge only.
- Monitor reset while the controller is mid-round: the monitor stays in SYNC until the next P3→P0 or DARK→P0 transition, and raises no false error.
- A nominal round is 8 cycles: P0×4, P1×1, P2×2, P3×1. After a controller reset, `TL` shows DARK for at least one cycle.

## Test plan
- **Nominal:** DARK ×2, then three rounds of P0×4, P1, P2×2, P3, then P0. Expect `err`=0, `last_len` sequence 4,1,2,1 repeating, and `cycle_done` pulsing once on each P3→P0 edge after the first full round. The first P0 is entered from DARK, so the first pulse occurs at the end of round 1.
- **Illegal pattern:** 100100 injected mid-P2. Expect `err`=1, `err_code`=1, `err_cnt`=1 on the next edge and FSM in SYNC. After DARK then P0, tracking resumes with `err` still 1.
- **Duration:** P0 held 5 cycles, then P1. Expect on the edge sampling P1: `err_code`=3, `last_len`=5, and no `cycle_done` at the end of that round.
- **Sequence:** P0×4 then P2. Expect `err_code`=2 and `err_cnt`=1. A second fault gives `err_cnt`=2 with `err_code` still 2.
- **Stuck:** P2 held 20 cycles. Expect `err_code`=4 on the edge where `run_len` reaches 12, exactly one increment of `err_cnt`, and `run_len` saturated at 15.
- **Reset mid-operation:** `reset` low for one edge during P1. Expect all outputs 0 after that edge. The remaining P1/P2/P3 raise no error, and TRACK resumes at the next P3→P0.

Source files
------------

// File: rtl/tl_monitor.sv
// Passive checker for the intersection traffic-light bus: decodes the 6-bit
// pattern into phases and checks legality, phase order, phase duration and stuck lights.
module tl_monitor #(
  parameter int unsigned G_MAIN  = 4,
  parameter int unsigned Y_MAIN  = 1,
  parameter int unsigned G_SIDE  = 2,
  parameter int unsigned Y_SIDE  = 1,
  parameter int unsigned MAX_RUN = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] TL,
  output logic [1:0] phase,
  output logic       phase_valid,
  output logic [3:0] last_len,
  output logic       cycle_done,
  output logic       err,
  output logic [2:0] err_code,
  output logic [7:0] err_cnt
);

  localparam logic [5:0] PAT_P0   = 6'b100001;
  localparam logic [5:0] PAT_P1   = 6'b010001;
  localparam logic [5:0] PAT_P2   = 6'b001100;
  localparam logic [5:0] PAT_P3   = 6'b001010;
  localparam logic [5:0] PAT_DARK = 6'b000000;
  localparam logic [5:0] PAT_UNK  = 6'b111111;

  localparam logic [3:0] LEN_SAT   = 4'hF;
  localparam logic [3:0] STUCK_PRE = 4'(MAX_RUN - 1);

  localparam logic [2:0] E_NONE     = 3'd0;
  localparam logic [2:0] E_ILLEGAL  = 3'd1;
  localparam logic [2:0] E_SEQUENCE = 3'd2;
  localparam logic [2:0] E_DURATION = 3'd3;
  localparam logic [2:0] E_STUCK    = 3'd4;

  typedef enum logic {
    SYNC,
    TRACK
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  tl_q, tl_d;
  logic [3:0]  run_len_q, run_len_d;
  logic        round_ok_q, round_ok_d;
  logic [1:0]  phase_q, phase_d;
  logic        phase_valid_q, phase_valid_d;
  logic [3:0]  last_len_q, last_len_d;
  logic        cycle_done_q, cycle_done_d;
  logic        err_q, err_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic        trans;
  logic        tl_leg, q_leg;
  logic [1:0]  tl_idx, q_idx;
  logic        tl_dark, tl_illegal;
  logic [2:0]  err_kind;

  // Returns {is_phase, phase_index}; DARK and illegal patterns decode as not-a-phase.
  function automatic logic [2:0] decode(input logic [5:0] p);
    logic [2:0] r;
    case (p)
      PAT_P0:  r = 3'b100;
      PAT_P1:  r = 3'b101;
      PAT_P2:  r = 3'b110;
      PAT_P3:  r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] req_len(input logic [1:0] idx);
    logic [3:0] r;
    case (idx)
      2'd0:    r = 4'(G_MAIN);
      2'd1:    r = 4'(Y_MAIN);
      2'd2:    r = 4'(G_SIDE);
      default: r = 4'(Y_SIDE);
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= SYNC;
      tl_q          <= PAT_UNK;
      run_len_q     <= '0;
      round_ok_q    <= 1'b0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      last_len_q    <= '0;
      cycle_done_q  <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= '0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      tl_q          <= tl_d;
      run_len_q     <= run_len_d;
      round_ok_q    <= round_ok_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      last_len_q    <= last_len_d;
      cycle_done_q  <= cycle_done_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tl_d          = TL;
    run_len_d     = run_len_q;
    round_ok_d    = round_ok_q;
    last_len_d    = last_len_q;
    cycle_done_d  = 1'b0;
    err_d         = err_q;
    err_code_d    = err_code_q;
    err_cnt_d     = err_cnt_q;
    err_kind      = E_NONE;

    trans           = (TL != tl_q);
    {tl_leg, tl_idx} = decode(TL);
    {q_leg, q_idx}   = decode(tl_q);
    tl_dark         = (TL == PAT_DARK);
    tl_illegal      = !tl_leg && !tl_dark;

    phase_d       = tl_leg ? tl_idx : 2'd0;
    phase_valid_d = tl_leg;

    if (trans) begin
      run_len_d = 4'd1;
      if (q_leg) begin
        last_len_d = run_len_q;
      end
    end else if (run_len_q != LEN_SAT) begin
      run_len_d = run_len_q + 4'd1;
    end

    case (state_q)
      SYNC: begin
        if (trans) begin
          if (tl_illegal) begin
            err_kind = E_ILLEGAL;
          end else if (TL == PAT_P0 && (tl_q == PAT_DARK || tl_q == PAT_P3)) begin
            state_d    = TRACK;
            round_ok_d = 1'b1;
          end
        end
      end
      TRACK: begin
        if (trans) begin
          if (tl_illegal) begin
            err_kind = E_ILLEGAL;
            state_d  = SYNC;
          end else if (tl_dark) begin
            state_d = SYNC;
          end else if (tl_idx != q_idx + 2'd1) begin
            err_kind = E_SEQUENCE;
            state_d  = SYNC;
          end else begin
            if (run_len_q != req_len(q_idx)) begin
              err_kind   = E_DURATION;
              round_ok_d = 1'b0;
            end
            // A P0 entry closes the old round and opens a fresh one.
            if (tl_idx == 2'd0) begin
              cycle_done_d = round_ok_q && (err_kind == E_NONE);
              round_ok_d   = 1'b1;
            end
          end
        end else if (run_len_q == STUCK_PRE) begin
          err_kind = E_STUCK;
          state_d  = SYNC;
        end
      end
      default: state_d = SYNC;
    endcase

    if (err_kind != E_NONE) begin
      err_d = 1'b1;
      if (!err_q) begin
        err_code_d = err_kind;
      end
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign last_len    = last_len_q;
  assign cycle_done  = cycle_done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_tl_monitor.sv
// Scenario bench for tl_monitor: expected outputs are queued as each pattern is
// driven and compared against the sampled outputs one edge later.
module tb_tl_monitor;

  typedef struct packed {
    logic [1:0] phase;
    logic       pv;
    logic [3:0] ll;
    logic       cd;
    logic       err;
    logic [2:0] code;
    logic [7:0] cnt;
  } obs_t;

  localparam logic [5:0] P0   = 6'b100001;
  localparam logic [5:0] P1   = 6'b010001;
  localparam logic [5:0] P2   = 6'b001100;
  localparam logic [5:0] P3   = 6'b001010;
  localparam logic [5:0] DARK = 6'b000000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] TL = DARK;
  logic [1:0] phase;
  logic       phase_valid;
  logic [3:0] last_len;
  logic       cycle_done;
  logic       err;
  logic [2:0] err_code;
  logic [7:0] err_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  obs_t        ex;
  obs_t        exp_q[$];
  obs_t        obs_q[$];
  logic [5:0]  pat[4];
  int          lens[4];

  tl_monitor #(
    .G_MAIN (4),
    .Y_MAIN (1),
    .G_SIDE (2),
    .Y_SIDE (1),
    .MAX_RUN(12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .TL         (TL),
    .phase      (phase),
    .phase_valid(phase_valid),
    .last_len   (last_len),
    .cycle_done (cycle_done),
    .err        (err),
    .err_code   (err_code),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  function automatic string fmt(input obs_t v);
    return $sformatf("ph=%0d v=%0b len=%0d cd=%0b err=%0b code=%0d cnt=%0d",
                     v.phase, v.pv, v.ll, v.cd, v.err, v.code, v.cnt);
  endfunction

  // Phase is don't-care while no legal phase is shown, so it is folded to 0.
  task automatic apply(input logic [5:0] v);
    obs_t o;
    TL = v;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    o = {(phase_valid ? phase : 2'd0), phase_valid, last_len, cycle_done,
         err, err_code, err_cnt};
    obs_q.push_back(o);
  endtask

  task automatic set_ph(input int p);
    if (p < 0) begin
      ex.phase = 2'd0;
      ex.pv    = 1'b0;
    end else begin
      ex.phase = 2'(p);
      ex.pv    = 1'b1;
    end
  endtask

  task automatic hold(input int p, input int n);
    set_ph(p);
    for (int i = 0; i < n; i++) begin
      apply(pat[p]);
      ex.cd = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    TL    = DARK;
    @(posedge clk);
    #1;
    reset = 1'b1;
    ex    = '0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    logic [19:0] got;
    reset = 1'b0;
    TL    = P0;
    repeat (2) @(posedge clk);
    #1;
    got = {phase, phase_valid, last_len, cycle_done, err, err_code, err_cnt};
    checks++;
    if (got !== 20'd0) begin
      errors++;
      $display("FAIL reset_initial: got %h want 00000", got);
    end
    reset = 1'b1;
    TL    = 6'b110000;
    @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL reset_prep_err: got err=%0b want 1", err);
    end
    reset = 1'b0;
    TL    = 6'b011000;
    @(posedge clk);
    #1;
    got = {phase, phase_valid, last_len, cycle_done, err, err_code, err_cnt};
    checks++;
    if (got !== 20'd0) begin
      errors++;
      $display("FAIL reset_override: got %h want 00000", got);
    end
    reset = 1'b1;
  endtask

  task automatic test_nominal();
    obs_t e, o;
    int   n;
    do_reset();
    set_ph(-1);
    apply(DARK);
    apply(DARK);
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < 4; p++) begin
        if (r == 3 && p > 0) break;
        if (r > 0 || p > 0) ex.ll = 4'(lens[(p + 3) % 4]);
        ex.cd = (r > 0 && p == 0);
        hold(p, lens[p]);
      end
    end
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL nominal step %0d: got %s want %s", n, fmt(o), fmt(e));
      end
      n++;
    end
  endtask

  task automatic test_illegal();
    obs_t e, o;
    int   n;
    do_reset();
    set_ph(-1);
    apply(DARK);
    hold(0, 4);
    ex.ll = 4;
    hold(1, 1);
    ex.ll = 1;
    hold(2, 1);
    set_ph(-1);
    ex.err  = 1'b1;
    ex.code = 3'd1;
    ex.cnt  = 8'd1;
    apply(6'b100100);
    apply(DARK);
    hold(0, 4);
    ex.ll = 4;
    hold(1, 2);
    ex.ll  = 2;
    ex.cnt = 8'd2;
    hold(2, 1);
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL illegal step %0d: got %s want %s", n, fmt(o), fmt(e));
      end
      n++;
    end
  endtask

  task automatic test_illegal_sync();
    obs_t e, o;
    int   n;
    do_reset();
    set_ph(-1);
    apply(DARK);
    ex.err  = 1'b1;
    ex.code = 3'd1;
    ex.cnt  = 8'd1;
    apply(6'b110000);
    apply(6'b110000);
    for (int i = 0; i < 300; i++) begin
      if (ex.cnt != 8'hFF) ex.cnt = ex.cnt + 8'd1;
      apply((i % 2 == 0) ? 6'b011000 : 6'b110000);
    end
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL illegal_sync step %0d: got %s want %s", n, fmt(o), fmt(e));
      end
      n++;
    end
  endtask

  task automatic test_duration();
    obs_t e, o;
    int   n;
    do_reset();
    set_ph(-1);
    apply(DARK);
    hold(0, 5);
    ex.ll   = 5;
    ex.err  = 1'b1;
    ex.code = 3'd3;
    ex.cnt  = 8'd1;
    hold(1, 1);
    ex.ll = 1;
    hold(2, 2);
    ex.ll = 2;
    hold(3, 1);
    ex.ll = 1;
    ex.cd = 1'b0;
    hold(0, 4);
    ex.ll = 4;
    hold(1, 1);
    ex.ll = 1;
    hold(2, 2);
    ex.ll = 2;
    hold(3, 1);
    ex.ll = 1;
    ex.cd = 1'b1;
    hold(0, 1);
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL duration step %0d: got %s want %s", n, fmt(o), fmt(e));
      end
      n++;
    end
  endtask

  task automatic test_sequence();
    obs_t e, o;
    int   n;
    do_reset();
    set_ph(-1);
    apply(DARK);
    hold(0, 4);
    ex.ll   = 4;
    ex.err  = 1'b1;
    ex.code = 3'd2;
    ex.cnt  = 8'd1;
    hold(2, 2);
    ex.ll = 2;
    hold(3, 1);
    ex.ll = 1;
    hold(0, 4);
    ex.ll = 4;
    hold(1, 1);
    ex.ll  = 1;
    ex.cnt = 8'd2;
    hold(3, 1);
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sequence step %0d: got %s want %s", n, fmt(o), fmt(e));
      end
      n++;
    end
  endtask

  task automatic test_stuck();
    obs_t e, o;
    int   n;
    do_reset();
    set_ph(-1);
    apply(DARK);
    hold(0, 4);
    ex.ll = 4;
    hold(1, 1);
    ex.ll = 1;
    set_ph(2);
    for (int k = 1; k <= 20; k++) begin
      if (k == 12) begin
        ex.err  = 1'b1;
        ex.code = 3'd4;
        ex.cnt  = 8'd1;
      end
      apply(P2);
    end
    ex.ll = 15;
    hold(3, 1);
    ex.ll = 1;
    hold(0, 1);
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stuck step %0d: got %s want %s", n, fmt(o), fmt(e));
      end
      n++;
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, o;
    int   n;
    do_reset();
    set_ph(-1);
    apply(DARK);
    hold(0, 4);
    reset = 1'b0;
    ex    = '0;
    apply(P1);
    reset = 1'b1;
    hold(2, 2);
    ex.ll = 2;
    hold(3, 1);
    ex.ll = 1;
    hold(0, 4);
    ex.ll = 4;
    hold(1, 1);
    ex.ll = 1;
    hold(2, 2);
    ex.ll = 2;
    hold(3, 1);
    ex.ll = 1;
    ex.cd = 1'b1;
    hold(0, 1);
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid step %0d: got %s want %s", n, fmt(o), fmt(e));
      end
      n++;
    end
  endtask

  initial begin
    pat[0]  = P0;
    pat[1]  = P1;
    pat[2]  = P2;
    pat[3]  = P3;
    lens[0] = 4;
    lens[1] = 1;
    lens[2] = 2;
    lens[3] = 1;
    ex      = '0;
    test_reset();
    test_nominal();
    test_illegal();
    test_illegal_sync();
    test_duration();
    test_sequence();
    test_stuck();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
